// File: rtl/pipe_stage_skid_if.sv
// Handshake bus for one side of pipe_stage_skid: valid/ready plus control, scalar and vector payload.
// Latency: none, plain bundle of wires.
// Backpressure: ready travels from the slave to the master; every other field travels master to slave.
interface pipe_stage_skid_if #(
  parameter int CW = 10,
  parameter int N  = 32,
  parameter int V  = 256,
  parameter int R  = 5
) ();
  logic          valid;
  logic          ready;
  logic [CW-1:0] ctrl;
  logic [N-1:0]  alu;
  logic [N-1:0]  wd;
  logic [V-1:0]  alu_v;
  logic [V-1:0]  wd_v;
  logic [R-1:0]  wa;

  modport master (output valid, ctrl, alu, wd, alu_v, wd_v, wa, input ready);
  modport slave  (input valid, ctrl, alu, wd, alu_v, wd_v, wa, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage for the SIMD datapath carrying control bits, scalar and vector words and a write address.
// Latency: 1 cycle from an accepted beat to out_valid when the stage is empty.
// Backpressure: SKID=1 holds up to 2 beats with in_ready decoded from state; SKID=0 holds 1 beat with in_ready = ~out_valid | out_ready.
module pipe_stage_skid #(
  parameter int CW   = 10,
  parameter int N    = 32,
  parameter int V    = 256,
  parameter int R    = 5,
  parameter int SKID = 1,
  parameter int SW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     clr_stats,
  pipe_stage_skid_if.slave         inIf,
  pipe_stage_skid_if.master        outIf,
  output logic [1:0]               occ,
  output logic [SW-1:0]            stall_cnt
);

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [N-1:0]  alu;
    logic [N-1:0]  wd;
    logic [V-1:0]  aluV;
    logic [V-1:0]  wdV;
    logic [R-1:0]  wa;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        stateQ;
  state_t        stateD;
  beat_t         mainQ;
  beat_t         skidQ;
  beat_t         inBeat;
  logic          inReady;
  logic          outValid;
  logic          inFire;
  logic          outFire;
  logic          loadMain;
  logic          loadSkid;
  logic          mainFromSkid;
  logic [SW-1:0] stallQ;

  assign inBeat  = {inIf.ctrl, inIf.alu, inIf.wd, inIf.alu_v, inIf.wd_v, inIf.wa};
  assign inFire  = inIf.valid & inReady;
  assign outFire = outValid & outIf.ready;

  // With the skid entry the ready depends only on state; without it, a held beat leaving frees the slot this cycle.
  generate
    if (SKID != 0) begin : gSkidReady
      assign inReady = ~rst & (stateQ != FULL);
    end else begin : gPassReady
      assign inReady = ~rst & (~outValid | outIf.ready);
    end
  endgenerate

  // State register: occupancy of the stage.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= EMPTY;
    else     stateQ <= stateD;
  end

  // Next state: flush empties the stage; otherwise follow accepted and emitted beats.
  always_comb begin
    stateD = stateQ;
    if (flush) begin
      stateD = EMPTY;
    end else begin
      case (stateQ)
        EMPTY:   if (inFire) stateD = ONE;
        ONE: begin
          if (inFire && !outFire)      stateD = FULL;
          else if (!inFire && outFire) stateD = EMPTY;
        end
        FULL:    if (outFire) stateD = ONE;
        default: stateD = EMPTY;
      endcase
    end
  end

  // Output decode: valid, occupancy and which register loads on this edge.
  always_comb begin
    outValid     = 1'b0;
    occ          = 2'd0;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    case (stateQ)
      EMPTY: loadMain = inFire;
      ONE: begin
        outValid = 1'b1;
        occ      = 2'd1;
        loadMain = inFire & outFire;
        loadSkid = inFire & ~outFire;
      end
      FULL: begin
        outValid     = 1'b1;
        occ          = 2'd2;
        loadMain     = outFire;
        mainFromSkid = 1'b1;
      end
      default: ;
    endcase
    // A flushed cycle keeps the old payload and drops any beat accepted alongside it.
    if (flush) begin
      loadMain = 1'b0;
      loadSkid = 1'b0;
    end
  end

  // Payload registers: head beat in main, overflow beat in skid; untouched while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainQ <= '0;
      skidQ <= '0;
    end else begin
      if (loadMain)              mainQ <= mainFromSkid ? skidQ : inBeat;
      if (loadSkid && SKID != 0) skidQ <= inBeat;
    end
  end

  // Stall counter: counts cycles the head beat is blocked, saturating; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats)                                  stallQ <= '0;
    else if (outValid && !outIf.ready && stallQ != '1)     stallQ <= stallQ + SW'(1);
  end

  assign inIf.ready   = inReady;
  assign outIf.valid  = outValid;
  assign outIf.ctrl   = outValid ? mainQ.ctrl : '0;
  assign outIf.alu    = mainQ.alu;
  assign outIf.wd     = mainQ.wd;
  assign outIf.alu_v  = mainQ.aluV;
  assign outIf.wd_v   = mainQ.wdV;
  assign outIf.wa     = mainQ.wa;
  assign stall_cnt    = stallQ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vectors on a skid instance (SW=4) and random traffic on a pass-through instance.
// Latency: scoreboard pops on every output handshake; directed steps check timing with hand-computed values.
// Backpressure: out_ready is driven per step; accepted input beats are queued, flush empties the queue.
module tb_pipe_stage_skid;
  localparam int CW = 10;
  localparam int N  = 32;
  localparam int V  = 256;
  localparam int R  = 5;
  localparam int PW = CW + 2*N + 2*V + R;

  typedef logic [PW-1:0] beatVec;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushA, clrA, flushB, clrB;
  logic [1:0]  occA, occB;
  logic [3:0]  stallA;
  logic [15:0] stallB;

  int checks = 0;
  int errors = 0;
  int recvB  = 0;
  int seq    = 0;

  beatVec qA[$];
  beatVec qB[$];
  beatVec aInVec, aOutVec, bInVec, bOutVec;

  pipe_stage_skid_if #(.CW(CW), .N(N), .V(V), .R(R)) aIn (), aOut (), bIn (), bOut ();

  pipe_stage_skid #(.CW(CW), .N(N), .V(V), .R(R), .SKID(1), .SW(4)) dutA (
    .clk(clk), .rst(rst), .flush(flushA), .clr_stats(clrA),
    .inIf(aIn), .outIf(aOut), .occ(occA), .stall_cnt(stallA)
  );

  pipe_stage_skid #(.CW(CW), .N(N), .V(V), .R(R), .SKID(0), .SW(16)) dutB (
    .clk(clk), .rst(rst), .flush(flushB), .clr_stats(clrB),
    .inIf(bIn), .outIf(bOut), .occ(occB), .stall_cnt(stallB)
  );

  always #5 clk = ~clk;

  assign aInVec  = {aIn.ctrl, aIn.alu, aIn.wd, aIn.alu_v, aIn.wd_v, aIn.wa};
  assign aOutVec = {aOut.ctrl, aOut.alu, aOut.wd, aOut.alu_v, aOut.wd_v, aOut.wa};
  assign bInVec  = {bIn.ctrl, bIn.alu, bIn.wd, bIn.alu_v, bIn.wd_v, bIn.wa};
  assign bOutVec = {bOut.ctrl, bOut.alu, bOut.wd, bOut.alu_v, bOut.wd_v, bOut.wa};

  function automatic beatVec mkBeat(input logic [CW-1:0] c, input logic [N-1:0] a);
    logic [N-1:0] w;
    w = a ^ 32'hA5A5_A5A5;
    return {c, a, w, {8{a}}, {8{w}}, a[R-1:0]};
  endfunction

  task automatic driveA(input logic v, input logic [CW-1:0] c, input logic [N-1:0] a);
    {aIn.ctrl, aIn.alu, aIn.wd, aIn.alu_v, aIn.wd_v, aIn.wa} = mkBeat(c, a);
    aIn.valid = v;
  endtask

  task automatic driveB(input logic v, input logic [CW-1:0] c, input logic [N-1:0] a);
    {bIn.ctrl, bIn.alu, bIn.wd, bIn.alu_v, bIn.wd_v, bIn.wa} = mkBeat(c, a);
    bIn.valid = v;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard for the skid instance: pop on output handshake, then account for the input side.
  always @(negedge clk) begin
    beatVec want;
    if (!rst) begin
      if (aOut.valid && aOut.ready) begin
        checks++;
        if (qA.size() == 0) begin
          errors++;
          $display("FAIL sbA unexpected beat got alu=%h", aOut.alu);
        end else begin
          want = qA.pop_front();
          if (aOutVec !== want) begin
            errors++;
            $display("FAIL sbA payload got ctrl=%h alu=%h want ctrl=%h alu=%h", aOut.ctrl, aOut.alu,
                     want[PW-1 -: CW], want[PW-CW-1 -: N]);
          end
        end
      end
      if (!aOut.valid) begin
        checks++;
        if (aOut.ctrl !== '0) begin
          errors++;
          $display("FAIL sbA bubble ctrl got %h want 0", aOut.ctrl);
        end
      end
      if (flushA) qA.delete();
      else if (aIn.valid && aIn.ready) qA.push_back(aInVec);
    end
  end

  // Scoreboard for the pass-through instance.
  always @(negedge clk) begin
    beatVec want;
    if (!rst) begin
      if (bOut.valid && bOut.ready) begin
        checks++;
        recvB++;
        if (qB.size() == 0) begin
          errors++;
          $display("FAIL sbB unexpected beat got alu=%h", bOut.alu);
        end else begin
          want = qB.pop_front();
          if (bOutVec !== want) begin
            errors++;
            $display("FAIL sbB payload got ctrl=%h alu=%h want ctrl=%h alu=%h", bOut.ctrl, bOut.alu,
                     want[PW-1 -: CW], want[PW-CW-1 -: N]);
          end
        end
      end
      if (flushB) qB.delete();
      else if (bIn.valid && bIn.ready) qB.push_back(bInVec);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed stimulus on the skid instance, then random traffic on the pass-through instance.
  initial begin
    rst = 1'b1; flushA = 1'b0; clrA = 1'b0; flushB = 1'b0; clrB = 1'b0;
    driveA(1'b0, '0, '0); driveB(1'b0, '0, '0);
    aOut.ready = 1'b0; bOut.ready = 1'b0;

    // reset: ready low during reset, clean state right after
    sample(); chk("rst inReadyA", 64'(aIn.ready), 0); chk("rst inReadyB", 64'(bIn.ready), 0);
    sample(); chk("rst inReadyA 2", 64'(aIn.ready), 0);
    step(); rst = 1'b0;
    sample();
    chk("rel occ", 64'(occA), 0); chk("rel valid", 64'(aOut.valid), 0);
    chk("rel ctrl", 64'(aOut.ctrl), 0); chk("rel stall", 64'(stallA), 0);
    chk("rel inReady", 64'(aIn.ready), 1); chk("rel alu", 64'(aOut.alu), 0);
    chk("rel inReadyB", 64'(bIn.ready), 1);
    step();

    // back-to-back stream 1..4 with out_ready high
    aOut.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      driveA(1'b1, 10'h001, 32'(i));
      sample();
      if (i > 1) begin
        chk("stream alu", 64'(aOut.alu), 64'(i - 1));
        chk("stream occ", 64'(occA), 1);
      end
      step();
    end
    driveA(1'b0, '0, '0);
    sample(); chk("stream last alu", 64'(aOut.alu), 4); chk("stream last occ", 64'(occA), 1);
    step();
    sample(); chk("stream drained", 64'(aOut.valid), 0);
    step();

    // fill to two beats, hold C upstream, then drain in order
    aOut.ready = 1'b0;
    driveA(1'b1, 10'h002, 32'h11); sample(); step();
    driveA(1'b1, 10'h003, 32'h22); sample(); chk("fill occ1", 64'(occA), 1); step();
    driveA(1'b1, 10'h004, 32'h33); sample();
    chk("full occ", 64'(occA), 2); chk("full inReady", 64'(aIn.ready), 0); chk("full head", 64'(aOut.alu), 32'h11);
    step();
    aOut.ready = 1'b1;
    sample(); chk("drain A", 64'(aOut.alu), 32'h11); chk("drain inReady", 64'(aIn.ready), 0); step();
    sample(); chk("drain B", 64'(aOut.alu), 32'h22); chk("drain inReady2", 64'(aIn.ready), 1); step();
    driveA(1'b0, '0, '0);
    sample(); chk("drain C", 64'(aOut.alu), 32'h33); chk("drain occ", 64'(occA), 1); step();
    sample(); chk("drain empty", 64'(occA), 0); step();

    // flush while full, then a beat with all control bits set
    aOut.ready = 1'b0;
    driveA(1'b1, 10'h005, 32'h44); sample(); step();
    driveA(1'b1, 10'h006, 32'h55); sample(); step();
    driveA(1'b1, 10'h007, 32'h66); flushA = 1'b1;
    sample(); chk("pre-flush occ", 64'(occA), 2); step();
    flushA = 1'b0; driveA(1'b1, 10'h3FF, 32'h77);
    sample();
    chk("flush occ", 64'(occA), 0); chk("flush valid", 64'(aOut.valid), 0);
    chk("flush ctrl", 64'(aOut.ctrl), 0); chk("flush held alu", 64'(aOut.alu), 32'h44);
    chk("flush inReady", 64'(aIn.ready), 1);
    step();
    driveA(1'b0, '0, '0); aOut.ready = 1'b1;
    sample(); chk("post-flush valid", 64'(aOut.valid), 1); chk("post-flush ctrl", 64'(aOut.ctrl), 10'h3FF);
    chk("post-flush alu", 64'(aOut.alu), 32'h77);
    step();

    // a beat accepted in the flush cycle is dropped
    aOut.ready = 1'b0;
    driveA(1'b1, 10'h008, 32'h88); sample(); step();
    driveA(1'b1, 10'h009, 32'h99); flushA = 1'b1;
    sample(); chk("drop inReady", 64'(aIn.ready), 1); step();
    flushA = 1'b0; driveA(1'b0, '0, '0);
    sample(); chk("drop occ", 64'(occA), 0); chk("drop held alu", 64'(aOut.alu), 32'h88); step();
    sample(); chk("drop never emitted", 64'(aOut.valid), 0); step();

    // stall counter: count, saturate at 15, clear beats increment, flush keeps it
    aOut.ready = 1'b0; clrA = 1'b1;
    driveA(1'b1, 10'h0AA, 32'hAB); sample(); step();
    clrA = 1'b0; driveA(1'b0, '0, '0);
    sample(); chk("stall start", 64'(stallA), 0); chk("stall valid", 64'(aOut.valid), 1);
    repeat (10) step();
    sample(); chk("stall 10", 64'(stallA), 10);
    repeat (10) step();
    sample(); chk("stall sat", 64'(stallA), 15);
    step(); clrA = 1'b1;
    sample(); step();
    clrA = 1'b0;
    sample(); chk("stall clr", 64'(stallA), 0);
    step();
    sample(); chk("stall after clr", 64'(stallA), 1);
    step(); flushA = 1'b1;
    sample(); step();
    flushA = 1'b0;
    sample(); chk("stall kept by flush", 64'(stallA), 3); chk("stall flush occ", 64'(occA), 0);
    step();
    sample(); chk("stall idle", 64'(stallA), 3);
    step();

    // pass-through instance under random traffic
    for (int c = 0; c < 1000; c++) begin
      driveB(1'($urandom_range(0, 1)), 10'(seq), 32'(seq));
      bOut.ready = 1'($urandom_range(0, 1));
      sample();
      chk("B occ<=1", 64'(occB <= 2'd1), 1);
      chk("B inReady", 64'(bIn.ready), 64'(!bOut.valid || bOut.ready));
      if (bIn.valid && bIn.ready) seq++;
      step();
    end
    driveB(1'b0, '0, '0); bOut.ready = 1'b1;
    repeat (3) begin sample(); step(); end
    sample();
    chk("B queue empty", 64'(qB.size()), 0);
    chk("B beats out", 64'(recvB), 64'(seq));
    chk("B drained occ", 64'(occB), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
